// File: rtl/kick_pkg.sv
// Shared types and field positions for the kick/chip pulse generator.
package kick_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BALL = 2'd1,
        FIRE      = 2'd2,
        COOLDOWN  = 2'd3
    } kick_state_t;

    // cmd_word fields, as written by software through the PIO out_port
    localparam int WIDTH_LSB   = 0;
    localparam int WIDTH_MSB   = 15;
    localparam int SEL_BIT     = 16;
    localparam int ARM_BIT     = 17;
    localparam int CLRDROP_BIT = 29;
    localparam int ABORT_BIT   = 30;
    localparam int TOGGLE_BIT  = 31;

    // status word fields, read back through the PIO in_port
    localparam int ST_COUNT_LSB = 0;
    localparam int ST_COUNT_MSB = 15;
    localparam int ST_BUSY_BIT  = 16;
    localparam int ST_STATE_LSB = 17;
    localparam int ST_STATE_MSB = 18;
    localparam int ST_DROP_BIT  = 19;

    // Limit a requested width to the largest pulse the solenoid driver allows.
    function automatic logic [15:0] clamp_width(input logic [15:0] w, input int unsigned max_w);
        if (32'(w) > max_w) begin
            return 16'(max_w);
        end
        return w;
    endfunction

endpackage

// File: rtl/kick_pulse_gen_tick_prescaler.sv
// Free-running timebase: one-cycle tick every PRESCALE clocks, re-phased by restart.
module tick_prescaler #(
    parameter int unsigned PRESCALE = 50
) (
    input  logic clk,
    input  logic reset_n,
    input  logic restart,
    output logic tick
);

    localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt;

    // Count 0..PRESCALE-1; restart re-aligns so the first tick lands PRESCALE cycles later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (restart || (cnt == LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // The tick is not masked by restart: the last tick of a pulse coincides with
    // the restart that starts the cooldown timebase.
    assign tick = (cnt == LAST);

endmodule

// File: rtl/kick_pulse_gen.sv
// Kick/chip solenoid pulse generator driven by a PIO command word.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | waiting for a trigger toggle on cmd_word[31]
// WAIT_BALL | armed request latched, waiting for synchronized ball_detect
// FIRE      | selected solenoid output driven for eff_width ticks
// COOLDOWN  | forced idle while the capacitor bank recharges
module kick_pulse_gen
    import kick_pkg::*;
#(
    parameter int unsigned PRESCALE       = 50,
    parameter int unsigned MAX_WIDTH      = 10000,
    parameter int unsigned COOLDOWN_TICKS = 500000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] cmd_word,
    input  logic        ball_detect,
    output logic        kick_out,
    output logic        chip_out,
    output logic        busy,
    output logic [31:0] status
);

    // The width field is 16 bits, so a MAX_WIDTH above 65535 never clamps.
    localparam int unsigned WIDTH_CAP = (MAX_WIDTH > 65535) ? 65535 : MAX_WIDTH;
    localparam int unsigned CNT_MAX   = (WIDTH_CAP > COOLDOWN_TICKS) ? WIDTH_CAP : COOLDOWN_TICKS;
    localparam int unsigned CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;

    kick_state_t state_q, state_d;

    logic             prev_toggle;
    logic             trig;
    logic             ball_meta, ball_s;
    logic             req_sel;
    logic [15:0]      req_width;
    logic [CNT_W-1:0] ticks_left;
    logic [15:0]      fire_count;
    logic             drop;
    logic             tick;
    logic             restart;
    logic             load_fire, load_cool, fire_done, drop_set;
    logic             fire_sel;
    logic [15:0]      fire_len;
    logic [15:0]      cmd_width;
    logic [15:0]      cmd_eff;
    logic             last_tick;
    logic [31:0]      status_d;
    logic             unused_cmd_bits;

    assign cmd_width       = cmd_word[WIDTH_MSB:WIDTH_LSB];
    assign cmd_eff         = clamp_width(cmd_width, MAX_WIDTH);
    assign trig            = cmd_word[TOGGLE_BIT] ^ prev_toggle;
    assign last_tick       = tick && (ticks_left == CNT_W'(1));
    assign restart         = load_fire | load_cool;
    assign busy            = (state_q != IDLE);
    assign unused_cmd_bits = ^cmd_word[28:18];

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .restart (restart),
        .tick    (tick)
    );

    // Toggle edge detector and two-flop ball_detect synchronizer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_toggle <= 1'b0;
            ball_meta   <= 1'b0;
            ball_s      <= 1'b0;
        end else begin
            prev_toggle <= cmd_word[TOGGLE_BIT];
            ball_meta   <= ball_detect;
            ball_s      <= ball_meta;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; in IDLE the request comes straight from cmd_word so the
    // output can rise on the cycle after the toggle.
    always_comb begin
        state_d   = state_q;
        load_fire = 1'b0;
        load_cool = 1'b0;
        fire_sel  = req_sel;
        fire_len  = req_width;
        case (state_q)
            IDLE: begin
                if (trig && (cmd_width != 16'd0)) begin
                    fire_sel = cmd_word[SEL_BIT];
                    fire_len = cmd_eff;
                    if (cmd_word[ARM_BIT]) begin
                        state_d = WAIT_BALL;
                    end else begin
                        state_d   = FIRE;
                        load_fire = 1'b1;
                    end
                end
            end
            WAIT_BALL: begin
                if (cmd_word[ABORT_BIT]) begin
                    state_d = IDLE;
                end else if (ball_s) begin
                    state_d   = FIRE;
                    load_fire = 1'b1;
                end
            end
            FIRE: begin
                if (last_tick) begin
                    state_d   = COOLDOWN;
                    load_cool = 1'b1;
                end
            end
            COOLDOWN: begin
                if (last_tick) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        fire_done = (state_q == FIRE) && load_cool;
        drop_set  = trig && (state_q != IDLE);
    end

    // Latch the request so later cmd_word edits cannot disturb an accepted pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_sel   <= 1'b0;
            req_width <= '0;
        end else if ((state_q == IDLE) && trig && (cmd_width != 16'd0)) begin
            req_sel   <= cmd_word[SEL_BIT];
            req_width <= cmd_eff;
        end
    end

    // Tick down-counter shared by pulse width and cooldown.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ticks_left <= '0;
        end else if (load_fire) begin
            ticks_left <= CNT_W'(fire_len);
        end else if (load_cool) begin
            ticks_left <= CNT_W'(COOLDOWN_TICKS);
        end else if (tick && busy && (state_q != WAIT_BALL) && (ticks_left != '0)) begin
            ticks_left <= ticks_left - CNT_W'(1);
        end
    end

    // Registered solenoid drives; at most one is high and only while in FIRE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            kick_out <= 1'b0;
            chip_out <= 1'b0;
        end else begin
            kick_out <= (state_d == FIRE) && !fire_sel;
            chip_out <= (state_d == FIRE) &&  fire_sel;
        end
    end

    // Pulse counter and sticky drop flag; a set wins over a same-cycle clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fire_count <= '0;
            drop       <= 1'b0;
        end else begin
            if (fire_done) begin
                fire_count <= fire_count + 16'd1;
            end
            if (drop_set) begin
                drop <= 1'b1;
            end else if (cmd_word[CLRDROP_BIT]) begin
                drop <= 1'b0;
            end
        end
    end

    // Assemble the status word from the current internal state.
    always_comb begin
        status_d                            = '0;
        status_d[ST_COUNT_MSB:ST_COUNT_LSB] = fire_count;
        status_d[ST_BUSY_BIT]               = busy;
        status_d[ST_STATE_MSB:ST_STATE_LSB] = state_q;
        status_d[ST_DROP_BIT]               = drop;
    end

    // Status is registered, so it trails the internal state by one cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            status <= '0;
        end else begin
            status <= status_d;
        end
    end

endmodule

// File: tb/tb_kick_pulse_gen.sv
// Directed test of kick_pulse_gen with PRESCALE=2, MAX_WIDTH=100, COOLDOWN_TICKS=4.
module tb_kick_pulse_gen;

    logic        clk;
    logic        reset_n;
    logic [31:0] cmd_word;
    logic        ball_detect;
    logic        kick_out;
    logic        chip_out;
    logic        busy;
    logic [31:0] status;

    int total;
    int bad;
    int nk, nc, nb, fk, fc;

    kick_pulse_gen #(
        .PRESCALE       (2),
        .MAX_WIDTH      (100),
        .COOLDOWN_TICKS (4)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cmd_word    (cmd_word),
        .ball_detect (ball_detect),
        .kick_out    (kick_out),
        .chip_out    (chip_out),
        .busy        (busy),
        .status      (status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] v);
        @(posedge clk);
        #1 cmd_word = v;
    endtask

    // Sample n negedges; count high cycles and first-high index of each output.
    task automatic sample(input int n, output int k, output int c, output int b,
                          output int first_k, output int first_c);
        k = 0; c = 0; b = 0; first_k = -1; first_c = -1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (kick_out) begin k++; if (first_k < 0) first_k = i; end
            if (chip_out) begin c++; if (first_c < 0) first_c = i; end
            if (busy) b++;
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        reset_n = 1'b0;
        cmd_word = 32'h0;
        ball_detect = 1'b0;
        #12;
        check("rst_kick", 32'(kick_out), 32'd0);
        check("rst_chip", 32'(chip_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_status", status, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        // Unarmed kick, width 5 ticks = 10 cycles, cooldown 8 cycles.
        drive(32'h8000_0005);
        sample(40, nk, nc, nb, fk, fc);
        check("kick1_count", 32'(nk), 32'd10);
        check("kick1_first", 32'(fk), 32'd1);
        check("kick1_chip", 32'(nc), 32'd0);
        check("kick1_busy", 32'(nb), 32'd18);
        check("kick1_status", status, 32'h0000_0001);

        // Armed chip, width 3 ticks; bit 31 toggles 1->0.
        drive(32'h0003_0003);
        sample(20, nk, nc, nb, fk, fc);
        check("arm_nochip", 32'(nc), 32'd0);
        check("arm_state", status, 32'h0003_0001);
        drive(32'h0003_0003);
        ball_detect = 1'b1;
        sample(40, nk, nc, nb, fk, fc);
        check("chip_first", 32'(fc), 32'd3);
        check("chip_count", 32'(nc), 32'd6);
        check("chip_kick", 32'(nk), 32'd0);
        check("chip_busy", 32'(nb), 32'd17);
        check("chip_status", status, 32'h0000_0002);
        ball_detect = 1'b0;

        // Width 500 clamps to 100 ticks.
        drive(32'h8000_01F4);
        sample(260, nk, nc, nb, fk, fc);
        check("clamp_count", 32'(nk), 32'd200);
        check("clamp_busy", 32'(nb), 32'd208);
        check("clamp_status", status, 32'h0000_0003);

        // Zero width is ignored without raising drop.
        drive(32'h0000_0000);
        sample(20, nk, nc, nb, fk, fc);
        check("zero_kick", 32'(nk), 32'd0);
        check("zero_busy", 32'(nb), 32'd0);
        check("zero_status", status, 32'h0000_0003);

        // Toggle during FIRE with clear also high: drop still sets, no second pulse.
        drive(32'h8000_0005);
        sample(4, nk, nc, nb, fk, fc);
        check("drop_pre", 32'(nk), 32'd3);
        drive(32'h2000_0005);
        drive(32'h0000_0005);
        sample(40, nk, nc, nb, fk, fc);
        check("drop_rest", 32'(nk), 32'd6);
        check("drop_busy", 32'(nb), 32'd14);
        check("drop_status", status, 32'h0008_0004);
        drive(32'h2000_0005);
        drive(32'h0000_0005);
        sample(2, nk, nc, nb, fk, fc);
        check("drop_clear", status, 32'h0000_0004);

        // Abort while waiting for the ball.
        drive(32'h8002_0005);
        sample(5, nk, nc, nb, fk, fc);
        check("abort_wait", status, 32'h0003_0004);
        drive(32'hC002_0005);
        sample(20, nk, nc, nb, fk, fc);
        check("abort_kick", 32'(nk), 32'd0);
        check("abort_busy", 32'(nb), 32'd1);
        check("abort_status", status, 32'h0000_0004);

        // Abort held high does not cut an unarmed pulse.
        drive(32'h4000_0005);
        sample(40, nk, nc, nb, fk, fc);
        check("abfire_count", 32'(nk), 32'd10);
        check("abfire_status", status, 32'h0000_0005);
        drive(32'h0000_0005);

        // Reset mid-pulse, then release with bit 31 still high.
        drive(32'h8000_0005);
        sample(4, nk, nc, nb, fk, fc);
        check("rstp_pre", 32'(nk), 32'd3);
        #2 reset_n = 1'b0;
        #1;
        check("rstp_kick", 32'(kick_out), 32'd0);
        check("rstp_status", status, 32'h0);
        check("rstp_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        sample(40, nk, nc, nb, fk, fc);
        check("rel_count", 32'(nk), 32'd10);
        check("rel_first", 32'(fk), 32'd0);
        check("rel_status", status, 32'h0000_0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/kick_pulse_gen.md
Name: kick_pulse_gen

Overview:
- Consumes the 32-bit command word driven by the Avalon PIO output register on the core board.
- Turns each software-issued trigger into one precisely timed kick or chip solenoid pulse.
- Supports optional gating on the ball-detect sensor and enforces a recharge cooldown.
- Exposes a 32-bit status word for a neighbouring PIO input register.

Parameters:
- PRESCALE, 50, clk cycles per timing tick (1 us at 50 MHz); must be >=1
- MAX_WIDTH, 10000, maximum pulse width in ticks; larger requests are clamped
- COOLDOWN_TICKS, 500000, ticks of forced idle after every pulse

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset, asynchronous, active-low
- cmd_word  in  32  command word from PIO out_port: [15:0] width (ticks), [16] sel (0 kick, 1 chip), [17] arm (wait for ball), [29] clear_drop (level), [30] abort (level), [31] trigger toggle
- ball_detect  in  1  asynchronous IR beam-break input, high = ball present
- kick_out  out  1  kick solenoid drive, registered
- chip_out  out  1  chip solenoid drive, registered
- busy  out  1  high whenever state != IDLE
- status  out  32  [15:0] fire_count, [16] busy, [18:17] state, [19] drop flag, [31:20] zero

Behaviour:
- Reset values: kick_out=0, chip_out=0, busy=0, status=0, state=IDLE, prev_toggle=0, ball sync flops=0, all counters=0.
- Trigger detection:
  - prev_toggle samples cmd_word[31] every cycle.
  - trig = cmd_word[31] ^ prev_toggle. It is a one-cycle event; only a change of bit 31 triggers.
- Request latch: on trig in IDLE, capture sel, arm and eff_width = min(width, MAX_WIDTH).
  - width==0: request is ignored and the FSM stays IDLE. This is not a drop.
- ball_detect passes through a 2-flop synchronizer; ball_s is the second flop output.
- FSM states, encoded 0..3:
  - IDLE(0):
    - trig with width!=0 and arm=0 -> FIRE.
    - trig with width!=0 and arm=1 -> WAIT_BALL.
  - WAIT_BALL(1):
    - abort=1 -> IDLE, with priority over ball_s.
    - otherwise ball_s=1 -> FIRE.
    - No timeout.
  - FIRE(2):
    - Selected output is high for exactly eff_width*PRESCALE cycles, starting the cycle after entry is registered. The prescaler and tick counter restart on entry.
    - On the final tick -> COOLDOWN, the output drops, and fire_count increments (wraps 0xFFFF->0).
    - abort is ignored in FIRE.
  - COOLDOWN(3): lasts COOLDOWN_TICKS*PRESCALE cycles, then -> IDLE.
- Latency:
  - Trigger edge at cycle N: kick_out/chip_out high from cycle N+1.
  - Armed case: output high 3 cycles after ball_detect rises (2 synchronizer + 1 state).
- Only one of kick_out/chip_out is ever high; both are 0 outside FIRE.
- trig while state != IDLE: the request is discarded and drop is set (sticky).
  - drop clears when cmd_word[29]=1.
  - A set and a clear in the same cycle leave drop set.
- cmd_word changes other than bit 31 during WAIT_BALL/FIRE do not affect the latched request.
- Asynchronous reset mid-pulse forces both outputs low immediately and returns the FSM to IDLE.
- The status register updates one cycle after the internal state changes.

Decomposition:
- Shared package kick_pkg:
  - state enum (IDLE, WAIT_BALL, FIRE, COOLDOWN, 2-bit)
  - cmd_word field index constants (WIDTH_LSB/MSB, SEL_BIT, ARM_BIT, CLRDROP_BIT, ABORT_BIT, TOGGLE_BIT)
  - status field index constants
- One sub-module tick_prescaler:
  - parameter PRESCALE; inputs clk, reset_n, restart; output tick (one-cycle pulse every PRESCALE cycles).
  - On restart its count returns to zero.
- FSM, width/cooldown counters, synchronizer and status logic live in kick_pulse_gen.

Test Plan (overrides PRESCALE=2, MAX_WIDTH=100, COOLDOWN_TICKS=4):
- Kick, unarmed: cmd_word 0x0000_0000->0x8000_0005 -> kick_out high exactly 10 cycles starting next cycle, chip_out 0; busy high 10+8 cycles; status[15:0]=1 afterwards.
- Chip, armed: write 0x8003_0003, hold ball_detect=0 for 20 cycles, then raise it -> chip_out high 3 cycles after rise, for 6 cycles; WAIT_BALL visible as status[18:17]=1.
- Clamp and zero width:
  - toggle with width 0x01F4 -> pulse 200 cycles (100 ticks).
  - toggle with width 0 -> no pulse, busy stays 0, drop=0.
- Drop/abort:
  - Toggle again during FIRE -> status[19]=1, no second pulse; setting bit 29 clears it.
  - Armed request, then bit 30 set -> back to IDLE, no pulse, fire_count unchanged.
- Reset mid-pulse: assert reset_n=0 during FIRE -> kick_out 0 asynchronously, status=0.
- Release reset with cmd_word[31] held at 1 -> one trigger fires (prev_toggle resets to 0).
